// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - imm_src encodings and default result width for the immediate extender
package imm_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IMM_8   = 2'b00,
    IMM_12  = 2'b01,
    IMM_BR  = 2'b10,
    IMM_ROT = 2'b11
  } imm_src_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - request/result handshake bundle for imm_extend_pipe
interface imm_extend_pipe_if
  import imm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [23:0]       instr;
  logic [1:0]        imm_src;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              carry_out;
  logic              err;

  modport master (
    output in_valid, instr, imm_src, carry_in, out_ready,
    input  in_ready, out_valid, ext_imm, carry_out, err
  );

  modport slave (
    input  in_valid, instr, imm_src, carry_in, out_ready,
    output in_ready, out_valid, ext_imm, carry_out, err
  );

endinterface

// File: rtl/imm_rotator.sv
// rtl/imm_rotator.sv - rotate-right by twice a 4-bit amount, with shifter carry-out
module imm_rotator #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        rot,
  input  logic              carry_in,
  output logic [DATA_W-1:0] dout,
  output logic              carry_out
);

  logic [4:0] amt;

  assign amt = {rot, 1'b0};

  // Modulo keeps the rotation correct when 2*rot can reach or exceed DATA_W.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dout[i] = din[(i + int'(amt)) % DATA_W];
    end
  end

  assign carry_out = (rot != 4'd0) ? dout[DATA_W-1] : carry_in;

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage immediate extender (S1 decode, S2 rotate/output)
// Mode 11 rotation is built only when IMM_EXTEND_ROT_EN is defined.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_base;
  logic              s1_carry;
  logic              s1_err;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_ext;
  logic              s2_carry;
  logic              s2_err;

  logic              s2_adv;
  logic [DATA_W-1:0] dec_base;
  logic              dec_err;
  logic [DATA_W-1:0] s2_ext_d;
  logic              s2_carry_d;

`ifdef IMM_EXTEND_ROT_EN
  logic              dec_is_rot;
  logic              s1_is_rot;
  logic [3:0]        s1_rot;
  logic [DATA_W-1:0] rot_dout;
  logic              rot_carry;
`endif

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;

  always_comb begin
    dec_base = '0;
    dec_err  = 1'b0;
`ifdef IMM_EXTEND_ROT_EN
    dec_is_rot = 1'b0;
`endif
    case (imm_src_e'(bus.imm_src))
      IMM_8:   dec_base = DATA_W'(bus.instr[7:0]);
      IMM_12:  dec_base = DATA_W'(bus.instr[11:0]);
      IMM_BR:  dec_base = DATA_W'($signed({bus.instr, 2'b00}));
      IMM_ROT: begin
`ifdef IMM_EXTEND_ROT_EN
        dec_base   = DATA_W'(bus.instr[7:0]);
        dec_is_rot = 1'b1;
`else
        dec_err    = 1'b1;
`endif
      end
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_base   <= '0;
      s1_carry  <= 1'b0;
      s1_err    <= 1'b0;
`ifdef IMM_EXTEND_ROT_EN
      s1_is_rot <= 1'b0;
      s1_rot    <= '0;
`endif
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_base   <= dec_base;
        s1_carry  <= bus.carry_in;
        s1_err    <= dec_err;
`ifdef IMM_EXTEND_ROT_EN
        s1_is_rot <= dec_is_rot;
        s1_rot    <= bus.instr[11:8];
`endif
      end
    end
  end

`ifdef IMM_EXTEND_ROT_EN
  imm_rotator #(
    .DATA_W(DATA_W)
  ) u_rotator (
    .din      (s1_base),
    .rot      (s1_rot),
    .carry_in (s1_carry),
    .dout     (rot_dout),
    .carry_out(rot_carry)
  );
`endif

  always_comb begin
    s2_ext_d   = s1_base;
    s2_carry_d = s1_carry;
`ifdef IMM_EXTEND_ROT_EN
    if (s1_is_rot) begin
      s2_ext_d   = rot_dout;
      s2_carry_d = rot_carry;
    end
`endif
  end

  // S2 only reloads on advance, so a stalled result holds stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_ext   <= '0;
      s2_carry <= 1'b0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ext   <= s2_ext_d;
        s2_carry <= s2_carry_d;
        s2_err   <= s1_err;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.ext_imm   = s2_ext;
  assign bus.carry_out = s2_carry;
  assign bus.err       = s2_err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed and scoreboarded checks for imm_extend_pipe
module tb_imm_extend_pipe;

  logic clk;
  logic reset;

  imm_extend_pipe_if #(.DATA_W(32)) bus ();

  imm_extend_pipe #(.DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks;
  int errors;

  logic [33:0] expq[$];
  logic [23:0] p_instr;
  logic [1:0]  p_src;
  logic        p_cin;
  int          accepted;
  int          popped;
  logic        hold_prev;
  logic [31:0] prev_ext;
  logic        prev_c;
  logic        prev_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {err, carry_out, ext_imm} for a 32-bit build.
  function automatic logic [33:0] model(input logic [23:0] i, input logic [1:0] s, input logic c);
    logic [31:0] v;
    logic        co;
    logic        e;
    int          n;
    v  = 32'h0;
    co = c;
    e  = 1'b0;
    case (s)
      2'b00: v = {24'h0, i[7:0]};
      2'b01: v = {20'h0, i[11:0]};
      2'b10: v = {{6{i[23]}}, i, 2'b00};
      default: begin
`ifdef IMM_EXTEND_ROT_EN
        v = {24'h0, i[7:0]};
        n = 2 * int'(i[11:8]);
        for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
        if (i[11:8] != 4'd0) co = v[31];
`else
        n = 0;
        e = 1'b1;
`endif
      end
    endcase
    return {e, co, v};
  endfunction

  task automatic new_req();
    p_instr = 24'($urandom);
    p_src   = 2'($urandom_range(0, 3));
    p_cin   = 1'($urandom_range(0, 1));
  endtask

  // One clock: entered and left at posedge+1.
  task automatic step(input logic iv, input logic ordy);
    logic [33:0] e;
    bus.in_valid  = iv;
    bus.instr     = p_instr;
    bus.imm_src   = p_src;
    bus.carry_in  = p_cin;
    bus.out_ready = ordy;
    @(negedge clk);
    if (hold_prev) begin
      check("hold out_valid", bus.out_valid, 1);
      check("hold ext_imm", bus.ext_imm, prev_ext);
      check("hold carry_out", bus.carry_out, prev_c);
      check("hold err", bus.err, prev_e);
    end
    hold_prev = bus.out_valid && !ordy;
    prev_ext  = bus.ext_imm;
    prev_c    = bus.carry_out;
    prev_e    = bus.err;
    if (bus.out_valid && ordy) begin
      if (expq.size() == 0) begin
        check("spurious out_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("stream ext_imm", bus.ext_imm, e[31:0]);
        check("stream carry_out", bus.carry_out, e[32]);
        check("stream err", bus.err, e[33]);
        popped++;
      end
    end
    if (iv && bus.in_ready) begin
      expq.push_back(model(p_instr, p_src, p_cin));
      accepted++;
      new_req();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_one(input string tag, input logic [23:0] i, input logic [1:0] s,
                           input logic c, input logic [31:0] e_ext, input logic e_c,
                           input logic e_err);
    int lat;
    bus.instr     = i;
    bus.imm_src   = s;
    bus.carry_in  = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " ext_imm"}, bus.ext_imm, e_ext);
    check({tag, " carry_out"}, bus.carry_out, e_c);
    check({tag, " err"}, bus.err, e_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    hold_prev = 1'b0;
    accepted  = 0;
    popped    = 0;
    bus.in_valid  = 1'b0;
    bus.instr     = 24'h0;
    bus.imm_src   = 2'b00;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", bus.out_valid, 0);
    check("rst ext_imm", bus.ext_imm, 0);
    check("rst carry_out", bus.carry_out, 0);
    check("rst err", bus.err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    apply_one("imm8 c1", 24'h0000AB, 2'b00, 1'b1, 32'h000000AB, 1'b1, 1'b0);
    apply_one("imm8 c0", 24'hFFFF5A, 2'b00, 1'b0, 32'h0000005A, 1'b0, 1'b0);
    apply_one("imm12", 24'h123ABC, 2'b01, 1'b1, 32'h00000ABC, 1'b1, 1'b0);
    apply_one("br neg", 24'hFFFFFE, 2'b10, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0);
    apply_one("br pos", 24'h000001, 2'b10, 1'b1, 32'h00000004, 1'b1, 1'b0);
    apply_one("br msb", 24'h800000, 2'b10, 1'b0, 32'hFE000000, 1'b0, 1'b0);
`ifdef IMM_EXTEND_ROT_EN
    apply_one("rot 4ff", 24'h0004FF, 2'b11, 1'b0, 32'hFF000000, 1'b1, 1'b0);
    apply_one("rot 0ff", 24'h0000FF, 2'b11, 1'b1, 32'h000000FF, 1'b1, 1'b0);
    apply_one("rot 102", 24'h000102, 2'b11, 1'b0, 32'h80000000, 1'b1, 1'b0);
    apply_one("rot 301", 24'h000301, 2'b11, 1'b1, 32'h04000000, 1'b0, 1'b0);
`else
    apply_one("rot off c0", 24'h0004FF, 2'b11, 1'b0, 32'h00000000, 1'b0, 1'b1);
    apply_one("rot off c1", 24'h0000FF, 2'b11, 1'b1, 32'h00000000, 1'b1, 1'b1);
`endif

    // Backpressure: four offers with out_ready low, then release.
    expq.delete();
    accepted  = 0;
    popped    = 0;
    hold_prev = 1'b0;
    new_req();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    check("bp accepted", accepted, 2);
    check("bp in_ready", bus.in_ready, 0);
    check("bp out_valid", bus.out_valid, 1);
    n = 0;
    while ((accepted < 4 || expq.size() != 0) && n < 50) begin
      step(accepted < 4, 1'b1);
      n++;
    end
    check("bp popped", popped, 4);

    // Asynchronous reset with both stages full.
    expq.delete();
    accepted = 0;
    popped   = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid full out_valid", bus.out_valid, 1);
    check("mid full in_ready", bus.in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async out_valid", bus.out_valid, 0);
    check("async ext_imm", bus.ext_imm, 0);
    check("async err", bus.err, 0);
    expq.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post rst in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
    check("post rst popped", popped, 0);

    // Random stream against the reference model.
    expq.delete();
    accepted  = 0;
    popped    = 0;
    hold_prev = 1'b0;
    new_req();
    n = 0;
    while ((accepted < 1000 || expq.size() != 0) && n < 20000) begin
      step((accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    check("rand accepted", accepted, 1000);
    check("rand popped", popped, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of extended immediate; SHALL be even and >= 26.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present on instr/imm_src/carry_in.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 instr  input  24  instruction bits [23:0].
REQ-007 imm_src  input  2  mode: 00 imm8, 01 imm12, 10 branch, 11 rotated imm8.
REQ-008 carry_in  input  1  current shifter carry flag, used when rotation amount is zero.
REQ-009 out_valid  output  1  result present on ext_imm/carry_out/err.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 ext_imm  output  DATA_W  extended immediate.
REQ-012 carry_out  output  1  shifter carry produced by the immediate.
REQ-013 err  output  1  request used an unsupported mode.

Function
REQ-014 Transfer occurs on in_valid&&in_ready (input) and on out_valid&&out_ready (output) at a rising edge.
REQ-015 Two-stage pipeline S1 (capture/decode), S2 (rotate/output); latency from accept to out_valid is exactly 2 cycles with no stall.
REQ-016 S2 advances when !s2_valid || out_ready; S1 advances when S2 can accept; in_ready = !s1_valid || S1 advances; throughput one per cycle with out_ready high.
REQ-017 While out_valid && !out_ready, ext_imm/carry_out/err SHALL hold stable; no request dropped or duplicated.
REQ-018 imm8: ext_imm = zero-extended instr[7:0]; carry_out = carry_in; err = 0.
REQ-019 imm12: ext_imm = zero-extended instr[11:0]; carry_out = carry_in; err = 0.
REQ-020 branch: ext_imm = {instr[23:0],2'b00} sign-extended from bit 25 to DATA_W; carry_out = carry_in; err = 0.
REQ-021 rotated: ext_imm = zero-extended instr[7:0] rotated right by 2*instr[11:8] within DATA_W; carry_out = ext_imm[DATA_W-1] if instr[11:8]!=0, else carry_in.
REQ-022 Unsupported mode: ext_imm = 0, carry_out = carry_in, err = 1; the request still consumes one pipeline slot.
REQ-023 Simultaneous S2 output transfer and new input acceptance in the same cycle SHALL be lossless.
REQ-024 No output SHALL ever be X; data registers of invalid stages may hold stale values but out_valid gates them.

Reset
REQ-025 On reset assertion, s1_valid, s2_valid, out_valid cleared immediately, ext_imm = 0, carry_out = 0, err = 0; in-flight requests discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-027 Macro IMM_EXTEND_ROT_EN defined: mode 11 behaves per REQ-021.
REQ-028 IMM_EXTEND_ROT_EN undefined: mode 11 is unsupported per REQ-022; no rotator logic synthesised.

Structure
REQ-029 Shared package imm_pkg SHALL hold the imm_src encoding constants (IMM_8, IMM_12, IMM_BR, IMM_ROT) and default DATA_W.
REQ-030 Rotation and carry logic SHALL live in combinational sub-module imm_rotator (parameter DATA_W), instantiated in S2 only when IMM_EXTEND_ROT_EN is defined.

Verification
REQ-031 imm8, instr=0x0000AB, out_ready=1 -> 2 cycles later ext_imm=0x000000AB, carry_out=carry_in, err=0.
REQ-032 branch, instr=0xFFFFFE -> ext_imm=0xFFFFFFF8; instr=0x000001 -> 0x00000004.
REQ-033 rotated, instr[11:0]=0x4FF, carry_in=0 -> ext_imm=0xFF000000, carry_out=1; instr[11:0]=0x0FF, carry_in=1 -> 0x000000FF, carry_out=1; with macro undefined -> ext_imm=0, err=1.
REQ-034 out_ready low, 4 back-to-back inputs -> 2 accepted, in_ready=0, outputs stable; release -> results in order, none lost.
REQ-035 Reset asserted asynchronously mid-stream with both stages full -> out_valid=0 immediately, no stale result after release.
REQ-036 Random 1000-request stream, random out_ready -> scoreboard matches REQ-018..022 in order.
